// File: rtl/itransform_recon_block_pkg.sv
// Shared constants, FSM state encoding and the fixed-point multiply used by the
// VP8 inverse 4x4 transform / reconstruction block.
package itransform_recon_block_pkg;

    localparam int ITX_K1        = 85627;   // 20091 + 65536
    localparam int ITX_K2        = 35468;
    localparam int ITX_MUL_SHIFT = 16;
    localparam int ITX_OUT_SHIFT = 3;
    localparam int PIX_MIN       = 0;
    localparam int PIX_MAX       = 255;

    typedef enum logic [2:0] {
        IDLE,
        VERT,
        HORZ,
        DCONLY,
        DONE
    } itx_state_e;

    // The product needs more than 32 bits; only the floored >>>16 result is kept.
    function automatic logic signed [31:0] itx_mul(input logic signed [31:0] x,
                                                   input logic signed [31:0] k);
        logic signed [63:0] xe;
        logic signed [63:0] ke;
        xe = 64'(x);
        ke = 64'(k);
        return 32'((xe * ke) >>> ITX_MUL_SHIFT);
    endfunction

endpackage

// File: rtl/itransform_recon_block_butterfly.sv
// Combinational 4-point VP8 inverse-transform butterfly, shared by the column
// and row passes; dc_bias adds the +4 rounding term to i0 for the row pass.
module itx_butterfly4
    import itransform_recon_block_pkg::*;
(
    input  logic signed [31:0] i0,
    input  logic signed [31:0] i1,
    input  logic signed [31:0] i2,
    input  logic signed [31:0] i3,
    input  logic               dc_bias,
    output logic signed [31:0] o0,
    output logic signed [31:0] o1,
    output logic signed [31:0] o2,
    output logic signed [31:0] o3
);

    logic signed [31:0] dc;
    logic signed [31:0] a;
    logic signed [31:0] b;
    logic signed [31:0] cc;
    logic signed [31:0] d;

    always_comb begin
        dc = i0 + (dc_bias ? 32'sd4 : 32'sd0);
        a  = dc + i2;
        b  = dc - i2;
        cc = itx_mul(i1, ITX_K2) - itx_mul(i3, ITX_K1);
        d  = itx_mul(i1, ITX_K1) + itx_mul(i3, ITX_K2);
        o0 = a + d;
        o1 = b + cc;
        o2 = b - cc;
        o3 = a - d;
    end

endmodule

// File: rtl/itransform_recon_block.sv
// VP8 inverse 4x4 transform + prediction add + clamp, one column then one row per cycle.
// Optional macro ITRANS_DC_FAST_EN: DC-only blocks bypass the passes via a 1-cycle DCONLY state.
module itransform_recon_block
    import itransform_recon_block_pkg::*;
#(
    parameter int BLOCK_SIZE = 4,
    parameter int IW         = 16,
    parameter int PW         = 8
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 start,
    input  logic [IW*BLOCK_SIZE*BLOCK_SIZE-1:0]  coeff,
    input  logic [PW*BLOCK_SIZE*BLOCK_SIZE-1:0]  pred,
    output logic [PW*BLOCK_SIZE*BLOCK_SIZE-1:0]  dst,
    output logic                                 busy,
    output logic                                 done
);

    localparam int NPIX = BLOCK_SIZE * BLOCK_SIZE;

    itx_state_e          state;
    itx_state_e          state_nx;
    logic [1:0]          cnt;
    logic signed [IW-1:0] coeff_q [NPIX];
    logic [PW-1:0]       pred_q [NPIX];
    logic signed [31:0]  tmp [4][4];   // tmp[column][row]

    logic signed [31:0]  bf_i0, bf_i1, bf_i2, bf_i3;
    logic                bf_dc_bias;
    logic signed [31:0]  bf_o [4];

    function automatic logic [PW-1:0] pix_recon(input logic [PW-1:0] p,
                                                input logic signed [31:0] v);
        logic signed [31:0] pe;
        logic signed [31:0] s;
        pe = {{(32-PW){1'b0}}, p};
        s  = pe + (v >>> ITX_OUT_SHIFT);
        if (s < PIX_MIN)
            return '0;
        else if (s > PIX_MAX)
            return PW'(PIX_MAX);
        else
            return s[PW-1:0];
    endfunction

`ifdef ITRANS_DC_FAST_EN
    logic ac_zero;
    assign ac_zero = (coeff[IW*NPIX-1:IW] == '0);
`endif

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (start) begin
`ifdef ITRANS_DC_FAST_EN
                    state_nx = ac_zero ? DCONLY : VERT;
`else
                    state_nx = VERT;
`endif
                end
            end
            VERT:   if (cnt == 2'd3) state_nx = HORZ;
            HORZ:   if (cnt == 2'd3) state_nx = DONE;
`ifdef ITRANS_DC_FAST_EN
            DCONLY: state_nx = DONE;
`endif
            DONE:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Butterfly operand select: coefficient column in VERT, tmp row in HORZ.
    always_comb begin
        bf_i0      = '0;
        bf_i1      = '0;
        bf_i2      = '0;
        bf_i3      = '0;
        bf_dc_bias = 1'b0;
        if (state == HORZ) begin
            bf_i0      = tmp[0][cnt];
            bf_i1      = tmp[1][cnt];
            bf_i2      = tmp[2][cnt];
            bf_i3      = tmp[3][cnt];
            bf_dc_bias = 1'b1;
        end else begin
            bf_i0 = 32'(coeff_q[{2'd0, cnt}]);
            bf_i1 = 32'(coeff_q[{2'd1, cnt}]);
            bf_i2 = 32'(coeff_q[{2'd2, cnt}]);
            bf_i3 = 32'(coeff_q[{2'd3, cnt}]);
        end
    end

    itx_butterfly4 u_bfly (
        .i0      (bf_i0),
        .i1      (bf_i1),
        .i2      (bf_i2),
        .i3      (bf_i3),
        .dc_bias (bf_dc_bias),
        .o0      (bf_o[0]),
        .o1      (bf_o[1]),
        .o2      (bf_o[2]),
        .o3      (bf_o[3])
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= (state_nx != state) ? 2'd0 : cnt + 2'd1;
            busy  <= (state == VERT) || (state == HORZ) || (state == DCONLY);
            done  <= (state == DONE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dst <= '0;
            for (int k = 0; k < NPIX; k++) begin
                coeff_q[k] <= '0;
                pred_q[k]  <= '0;
            end
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    tmp[c][r] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        for (int k = 0; k < NPIX; k++) begin
                            coeff_q[k] <= coeff[IW*k +: IW];
                            pred_q[k]  <= pred[PW*k +: PW];
                        end
                    end
                end
                VERT: begin
                    for (int r = 0; r < 4; r++)
                        tmp[cnt][r] <= bf_o[r];
                end
                HORZ: begin
                    for (int x = 0; x < 4; x++)
                        dst[PW*(int'(cnt)*4 + x) +: PW] <= pix_recon(pred_q[int'(cnt)*4 + x], bf_o[x]);
                end
`ifdef ITRANS_DC_FAST_EN
                DCONLY: begin
                    for (int k = 0; k < NPIX; k++)
                        dst[PW*k +: PW] <= pix_recon(pred_q[k], 32'(coeff_q[0]) + 32'sd4);
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_itransform_recon_block.sv
// Directed-table and random-block bench for itransform_recon_block.
module tb_itransform_recon_block;

    localparam int IW = 16;
    localparam int PW = 8;
    localparam longint K1 = 85627;
    localparam longint K2 = 35468;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [IW*16-1:0]  coeff = '0;
    logic [PW*16-1:0]  pred = '0;
    logic [PW*16-1:0]  dst;
    logic              busy;
    logic              done;

    int n_err = 0;
    int n_chk = 0;

    int mc [16];
    int mp [16];
    int md [16];

    typedef struct {
        int c0;
        int c1;
        int p;
        int e0;
        int e1;
        int e2;
        int e3;
    } vec_t;

    vec_t tbl [5];

    itransform_recon_block #(.BLOCK_SIZE(4), .IW(IW), .PW(PW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .coeff (coeff),
        .pred  (pred),
        .dst   (dst),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int sat16(input int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    function automatic longint mulk(input longint x, input longint k);
        return (x * k) >>> 16;
    endfunction

    function automatic void run_model();
        longint t [4][4];
        longint i0, i1, i2, i3, a, b, cp, d, dc, px;
        longint v [4];
        for (int c = 0; c < 4; c++) begin
            i0 = mc[c]; i1 = mc[4+c]; i2 = mc[8+c]; i3 = mc[12+c];
            a  = i0 + i2;
            b  = i0 - i2;
            cp = mulk(i1, K2) - mulk(i3, K1);
            d  = mulk(i1, K1) + mulk(i3, K2);
            t[c][0] = a + d; t[c][1] = b + cp; t[c][2] = b - cp; t[c][3] = a - d;
        end
        for (int r = 0; r < 4; r++) begin
            dc = t[0][r] + 4;
            a  = dc + t[2][r];
            b  = dc - t[2][r];
            cp = mulk(t[1][r], K2) - mulk(t[3][r], K1);
            d  = mulk(t[1][r], K1) + mulk(t[3][r], K2);
            v[0] = a + d; v[1] = b + cp; v[2] = b - cp; v[3] = a - d;
            for (int x = 0; x < 4; x++) begin
                px = longint'(mp[r*4+x]) + (v[x] >>> 3);
                if (px < 0) px = 0;
                if (px > 255) px = 255;
                md[r*4+x] = int'(px);
            end
        end
    endfunction

    function automatic int exp_latency();
`ifdef ITRANS_DC_FAST_EN
        bit ac0;
        ac0 = 1'b1;
        for (int k = 1; k < 16; k++)
            if (mc[k] != 0) ac0 = 1'b0;
        if (ac0) return 2;
`endif
        return 9;
    endfunction

    task automatic check_rows(input string tag);
        longint expv;
        for (int r = 0; r < 4; r++) begin
            expv = 0;
            for (int x = 0; x < 4; x++)
                expv = expv | (longint'(md[r*4+x] & 255) << (8*x));
            check($sformatf("%s dst row%0d", tag, r), longint'(dst[32*r +: 32]), expv);
        end
    endtask

    task automatic drive_inputs();
        for (int k = 0; k < 16; k++) begin
            coeff[IW*k +: IW] = mc[k][15:0];
            pred[PW*k +: PW]  = mp[k][7:0];
        end
    endtask

    // Called just after a rising edge; start is sampled on the next edge (T).
    task automatic run_block(input string tag);
        int lat;
        int el;
        el = exp_latency();
        drive_inputs();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        coeff = {8{$urandom()}};
        pred  = {4{$urandom()}};
        lat = -1;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            if (n == 1) check({tag, " busy after start"}, longint'(busy), 1);
            if (done) begin
                lat = n;
                break;
            end
        end
        check({tag, " latency"}, lat, el);
        check({tag, " busy at done"}, longint'(busy), 0);
        check_rows(tag);
    endtask

    task automatic load_vec(input vec_t v);
        for (int k = 0; k < 16; k++) begin
            mc[k] = 0;
            mp[k] = v.p;
        end
        mc[0] = v.c0;
        mc[1] = v.c1;
        for (int r = 0; r < 4; r++) begin
            md[r*4+0] = v.e0; md[r*4+1] = v.e1;
            md[r*4+2] = v.e2; md[r*4+3] = v.e3;
        end
    endtask

    initial begin
        int dcnt;
        int first;
        int rv;

        tbl[0] = '{c0: 0,    c1: 0,  p: 128, e0: 128, e1: 128, e2: 128, e3: 128};
        tbl[1] = '{c0: 80,   c1: 0,  p: 100, e0: 110, e1: 110, e2: 110, e3: 110};
        tbl[2] = '{c0: 800,  c1: 0,  p: 250, e0: 255, e1: 255, e2: 255, e3: 255};
        tbl[3] = '{c0: -800, c1: 0,  p: 10,  e0: 0,   e1: 0,   e2: 0,   e3: 0};
        tbl[4] = '{c0: 0,    c1: 64, p: 128, e0: 138, e1: 132, e2: 124, e3: 118};

        // Reset state
        #22;
        for (int k = 0; k < 16; k++) md[k] = 0;
        check("reset busy", longint'(busy), 0);
        check("reset done", longint'(done), 0);
        check_rows("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 5; i++) begin
            load_vec(tbl[i]);
            run_block($sformatf("vec%0d", i));
        end

        // start re-pulsed during VERT and during DONE must be ignored
        load_vec(tbl[4]);
        drive_inputs();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        dcnt = 0;
        first = -1;
        for (int n = 1; n <= 25; n++) begin
            @(posedge clk); #1;
            if (done) begin
                dcnt++;
                if (first < 0) first = n;
            end
            start = (n == 2 || n == 8);
        end
        start = 1'b0;
        check("hs done count", dcnt, 1);
        check("hs done cycle", first, 9);
        check_rows("hs");

        // Reset asserted mid-operation aborts without a done pulse
        load_vec(tbl[4]);
        drive_inputs();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        dcnt = 0;
        for (int n = 1; n <= 5; n++) begin
            @(posedge clk); #1;
            if (done) dcnt++;
        end
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 16; k++) md[k] = 0;
        check("midrst busy", longint'(busy), 0);
        check("midrst done", longint'(done), 0);
        check_rows("midrst");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int n = 0; n < 12; n++) begin
            @(posedge clk); #1;
            if (done) dcnt++;
        end
        check("midrst done pulses", dcnt, 0);
        load_vec(tbl[1]);
        run_block("post-reset");

        // Back-to-back random blocks against the software model
        for (int b = 0; b < 1000; b++) begin
            for (int k = 0; k < 16; k++) begin
                rv = int'($urandom_range(2047*127 + 2048*127)) - 2048*127;
                mc[k] = (b % 8 == 0 && k != 0) ? 0 : sat16(rv);
                mp[k] = int'($urandom_range(255));
            end
            run_model();
            run_block($sformatf("rand%0d", b));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/itransform_recon_block.md
Name: itransform_recon_block

Overview:
- Reconstruction stage directly downstream of the quantizer. It consumes the dequantized 4x4 coefficients (the quantizer's raster-order Rout bus) and the 4x4 8-bit prediction block.
- Performs the VP8 inverse 4x4 transform (vertical pass, then horizontal pass), adds the result to the prediction and clamps to 8 bits.
- Produces reconstructed pixels for the intra-prediction neighbour buffers and the distortion calculation.
- Multi-cycle: one column per cycle, then one row per cycle, with a start/done handshake.

Parameters:
- BLOCK_SIZE, 4, block edge; fixed at 4, no other value is supported.
- IW, 16, signed width of each input coefficient.
- PW, 8, unsigned pixel width for prediction and output.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle request; sampled only when idle.
- coeff  input  IW*16  dequantized coefficients, raster order; element k = row*4+col at bits [IW*(k+1)-1 : IW*k], signed.
- pred  input  PW*16  prediction pixels, raster order, unsigned.
- dst  output  PW*16  reconstructed pixels, raster order, registered.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse; dst is valid from this cycle.

Behaviour:
- Interface: one clock clk; reset rst_n is asynchronous, active-low.
- Reset values: dst=0, busy=0, done=0, FSM=IDLE, all internal tmp registers 0. Reset asserted mid-operation aborts immediately; no done is issued.
- Input capture: when start=1 in IDLE, coeff and pred are registered at that edge (edge T). Inputs may change afterwards.
- FSM:
  - IDLE -> VERT on start.
  - VERT: 4 cycles, column counter c=0..3.
  - HORZ: 4 cycles, row counter r=0..3.
  - DONE: 1 cycle; done=1, busy=0.
  - DONE -> IDLE.
  - done rises at edge T+9, so latency is 9 cycles.
- start is ignored while not in IDLE. start asserted in the DONE cycle is also ignored; back-to-back throughput is one block per 10 cycles.
- Constants and rounding:
  - K1=85627 (20091+65536), K2=35468.
  - MUL(x,k) = (x*k)>>>16, arithmetic shift (floor).
- Vertical pass, column c, with i0..i3 = coeff[c], coeff[4+c], coeff[8+c], coeff[12+c]:
  - a=i0+i2, b=i0-i2, c'=MUL(i1,K2)-MUL(i3,K1), d=MUL(i1,K1)+MUL(i3,K2).
  - tmp[c][0..3] = a+d, b+c', b-c', a-d.
- Horizontal pass, row r, with t0..t3 = tmp[0][r], tmp[1][r], tmp[2][r], tmp[3][r]:
  - dc=t0+4, a=dc+t2, b=dc-t2, c' and d formed as in the vertical pass from t1 and t3.
  - v[0..3] = a+d, b+c', b-c', a-d.
  - dst[r*4+x] = clamp(pred[r*4+x] + (v[x]>>>3), 0, 255).
- Widths: all intermediates are 32-bit signed, so no overflow for any 16-bit input.
- The dst register is updated one row per HORZ cycle. Only the value at done is defined; it holds until the next block's HORZ cycles.

Optional Feature:
- Macro ITRANS_DC_FAST_EN.
- Defined: at capture, if coeff elements 1..15 are all zero, the FSM goes IDLE -> DCONLY (1 cycle) -> DONE.
  - DCONLY writes all 16 pixels as dst[k] = clamp(pred[k] + ((coeff[0]+4)>>>3)).
  - This is bit-identical to the full path; done rises at T+2.
- Undefined: all blocks take the 9-cycle path and the DCONLY state does not exist.

Decomposition:
- Shared package holds:
  - ITX_K1, ITX_K2 and the shift constants (16, 3).
  - The pixel clamp limits.
  - The FSM state enum (IDLE, VERT, HORZ, DCONLY, DONE).
- Natural sub-module itx_butterfly4: combinational 4-point butterfly with inputs i0..i3, optional +4 dc bias, outputs o0..o3. One instance is shared between both passes and muxed by state.

Test Plan:
- All coeff=0, pred=128 everywhere -> done at T+9 (T+2 with ITRANS_DC_FAST_EN), all dst=128.
- coeff[0]=80, others 0, pred=100 -> all dst=110.
- Clamp both ends:
  - coeff[0]=800, pred=250 -> all dst=255.
  - coeff[0]=-800, pred=10 -> all dst=0.
- coeff[1]=64, others 0, pred=128 -> every row = 138,132,124,118 (checks floor on negative shifts).
- Handshake: start re-pulsed during VERT and during DONE -> ignored, exactly one done pulse. Back-to-back blocks at 10-cycle spacing each match the software model on 1000 random blocks (coeff in [-2048*127, 2047*127] saturated to 16 bits).
- rst_n asserted at T+5 -> dst=0, busy=0, done never pulses. A new start after release completes normally.
